// File: rtl/packing_dispatcher_pkg.sv
// Shared line codes, line count and dispatcher FSM states for the packing stage.
// Line code = counter bit index + 1; 0 means no box.
package packing_dispatcher_pkg;

   localparam int NUM_LINES = 5;
   localparam int CODE_W    = 3;

   typedef logic [CODE_W-1:0] code_t;

   localparam code_t LINE_NONE = 3'd0;
   localparam code_t AL_BAJO   = 3'd1;
   localparam code_t POL_BAJO  = 3'd2;
   localparam code_t AC_BAJO   = 3'd3;
   localparam code_t AL_ALTO   = 3'd4;
   localparam code_t AC_ALTO   = 3'd5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PACK    = 2'd1,
      PRESENT = 2'd2
   } state_t;

   // Line index reached by stepping offs places from base, wrapping past the last line.
   function automatic logic [2:0] rr_index(input logic [2:0] base, input int offs);
      int s;
      s = int'(base) + offs;
      if (s >= NUM_LINES) s = s - NUM_LINES;
      return 3'(s);
   endfunction

endpackage

// File: rtl/packing_fifo.sv
// Small synchronous FIFO holding queued box codes; head word is readable combinationally.
// Zero-latency read of the head; a push into a full FIFO succeeds only alongside a pop.
module packing_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_push,
   input  logic [W-1:0] i_push_dat,
   input  logic         i_pop,
   output logic [W-1:0] o_pop_dat,
   output logic         o_full,
   output logic         o_empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_occ;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_occ == CW'(DEPTH));
   assign o_empty   = (r_occ == '0);
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_pop_dat = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_do_push && !w_do_pop)      r_occ <= r_occ + 1'b1;
         else if (w_do_pop && !w_do_push) r_occ <= r_occ - 1'b1;
      end
   end

endmodule

// File: rtl/packing_dispatcher.sv
// Round-robin collector of sock-line package requests feeding one timed packer and a valid/ready box output.
// Request to box_valid is PACK_CYCLES+2 cycles when idle; a held box waits for box_ready, stop freezes packing.
module packing_dispatcher
   import packing_dispatcher_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int PACK_CYCLES = 12,
   parameter int CNT_W       = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_LINES-1:0] co_req,
   input  logic                 stop,
   input  logic                 box_ready,
   output logic [NUM_LINES-1:0] clr_cnt,
   output logic                 pack_busy,
   output logic                 box_valid,
   output logic [CODE_W-1:0]    box_code,
   output logic                 fifo_full,
   output logic [CNT_W-1:0]     box_count
);
   localparam int TW = (PACK_CYCLES > 1) ? $clog2(PACK_CYCLES) : 1;
   localparam logic [TW-1:0] TLOAD = TW'(PACK_CYCLES - 1);

   logic [NUM_LINES-1:0] r_clr_cnt;
   logic [2:0]           r_rr_ptr;
   state_t               r_state;
   logic [TW-1:0]        r_timer;
   code_t                r_code;
   logic [CNT_W-1:0]     r_count;

   logic [NUM_LINES-1:0] w_elig;
   logic                 w_grant_vld;
   logic [2:0]           w_grant_idx;
   logic                 w_push;
   logic [NUM_LINES-1:0] w_clr_nxt;
   state_t               w_state_nxt;
   logic                 w_pop;
   code_t                w_head;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic                 w_handshake;

   // A line whose counter is clearing this cycle still shows its stale request.
   assign w_elig = co_req & ~r_clr_cnt;

   always_comb begin
      w_grant_vld = 1'b0;
      w_grant_idx = '0;
      for (int k = 0; k < NUM_LINES; k++) begin
         if (!w_grant_vld && w_elig[rr_index(r_rr_ptr, k)]) begin
            w_grant_vld = 1'b1;
            w_grant_idx = rr_index(r_rr_ptr, k);
         end
      end
   end

   assign w_push = w_grant_vld & ~w_fifo_full;

   always_comb begin
      w_clr_nxt = '0;
      if (w_push) w_clr_nxt[w_grant_idx] = 1'b1;
   end

   packing_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (CODE_W)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_push     (w_push),
      .i_push_dat (code_t'(w_grant_idx + 3'd1)),
      .i_pop      (w_pop),
      .o_pop_dat  (w_head),
      .o_full     (w_fifo_full),
      .o_empty    (w_fifo_empty)
   );

   assign w_handshake = (r_state == PRESENT) & box_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_fifo_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = PACK;
            end
         end
         PACK: begin
            if (!stop && r_timer == '0) w_state_nxt = PRESENT;
         end
         PRESENT: begin
            if (box_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_clr_cnt <= '0;
         r_rr_ptr  <= '0;
         r_state   <= IDLE;
         r_timer   <= '0;
         r_code    <= LINE_NONE;
         r_count   <= '0;
      end else begin
         r_clr_cnt <= w_clr_nxt;
         if (w_push) r_rr_ptr <= rr_index(w_grant_idx, 1);
         r_state <= w_state_nxt;
         if (w_pop) begin
            r_code  <= w_head;
            r_timer <= TLOAD;
         end else if (r_state == PACK && !stop && r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
         end
         if (w_handshake && r_count != '1) r_count <= r_count + CNT_W'(1);
      end
   end

   assign clr_cnt   = r_clr_cnt;
   assign pack_busy = (r_state == PACK);
   assign box_valid = (r_state == PRESENT);
   assign box_code  = box_valid ? r_code : LINE_NONE;
   assign fifo_full = w_fifo_full;
   assign box_count = r_count;

endmodule

// File: tb/tb_packing_dispatcher.sv
// Directed bench for packing_dispatcher: queue-based reference model checked every cycle,
// plus hand-computed expectations for latency, ordering, stalls, reset and saturation.
module tb_packing_dispatcher;
   localparam int DEPTH = 4;
   localparam int PC    = 12;
   localparam int CW    = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] co_req = '0;
   logic       stop = 1'b0;
   logic       box_ready = 1'b0;
   logic [4:0] clr_cnt;
   logic       pack_busy;
   logic       box_valid;
   logic [2:0] box_code;
   logic       fifo_full;
   logic [CW-1:0] box_count;

   packing_dispatcher #(.FIFO_DEPTH(DEPTH), .PACK_CYCLES(PC), .CNT_W(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .co_req    (co_req),
      .stop      (stop),
      .box_ready (box_ready),
      .clr_cnt   (clr_cnt),
      .pack_busy (pack_busy),
      .box_valid (box_valid),
      .box_code  (box_code),
      .fifo_full (fifo_full),
      .box_count (box_count)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   bit auto_drop = 1'b0;
   int delivered[$];

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   // Reference model: a queue of codes, a box phase (0 idle, 1 packing, 2 presenting) and a countdown.
   int         mq[$];
   logic [4:0] m_clr;
   logic [4:0] m_elig;
   logic [4:0] m_nclr;
   int m_rr, m_mode, m_timer, m_code, m_cnt, m_pre, m_push, m_idx;
   bit m_on = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         mq.delete();
         m_clr = '0; m_rr = 0; m_mode = 0; m_timer = 0; m_code = 0; m_cnt = 0;
         m_on = 1'b1;
      end else if (m_on) begin
         m_pre  = mq.size();
         m_push = 0;
         m_nclr = '0;
         m_elig = co_req & ~m_clr;
         if (m_pre < DEPTH) begin
            for (int k = 0; k < 5; k++) begin
               m_idx = (m_rr + k) % 5;
               if (m_push == 0 && m_elig[m_idx]) begin
                  m_push = m_idx + 1;
                  m_nclr[m_idx] = 1'b1;
               end
            end
         end
         if (m_push != 0) m_rr = m_push % 5;
         case (m_mode)
            0: if (m_pre > 0) begin m_code = mq.pop_front(); m_timer = PC - 1; m_mode = 1; end
            1: if (!stop) begin
                  if (m_timer == 0) m_mode = 2;
                  else m_timer--;
               end
            default: if (box_ready) begin
                  if (m_cnt < (1 << CW) - 1) m_cnt++;
                  m_mode = 0;
               end
         endcase
         if (m_push != 0) mq.push_back(m_push);
         m_clr = m_nclr;
      end
   end

   always @(negedge clk) begin
      if (m_on) begin
         check("cmp_clr_cnt",   int'(clr_cnt),   int'(m_clr));
         check("cmp_pack_busy", int'(pack_busy), int'(m_mode == 1));
         check("cmp_box_valid", int'(box_valid), int'(m_mode == 2));
         check("cmp_box_code",  int'(box_code),  (m_mode == 2) ? m_code : 0);
         check("cmp_fifo_full", int'(fifo_full), int'(mq.size() == DEPTH));
         check("cmp_box_count", int'(box_count), m_cnt);
         if (box_valid && box_ready && !reset) delivered.push_back(int'(box_code));
      end
   end

   task automatic step();
      logic [4:0] pre;
      pre = clr_cnt;
      @(posedge clk);
      #1;
      if (auto_drop) co_req = co_req & ~pre;
   endtask

   // Cycles from now until box_valid, with stop raised over [stop_at, stop_at+stop_len).
   task automatic run_pack(input int stop_at, input int stop_len, output int took);
      took = -1;
      for (int i = 0; i < 80; i++) begin
         stop = (i >= stop_at) && (i < stop_at + stop_len);
         if (box_valid) begin
            took = i;
            break;
         end
         step();
      end
      stop = 1'b0;
   endtask

   int  took;
   int  highs;
   bit  seen_full;

   initial begin
      reset = 1'b1; co_req = 5'b11111; box_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_clr_cnt",   int'(clr_cnt),   0);
      check("rst_pack_busy", int'(pack_busy), 0);
      check("rst_box_valid", int'(box_valid), 0);
      check("rst_box_code",  int'(box_code),  0);
      check("rst_fifo_full", int'(fifo_full), 0);
      check("rst_box_count", int'(box_count), 0);

      // All five lines request at once.
      reset = 1'b0; box_ready = 1'b1; auto_drop = 1'b1;
      step();
      check("first_clr_bit0", int'(clr_cnt), 1);
      step();
      check("second_clr_bit1", int'(clr_cnt), 2);
      seen_full = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (delivered.size() >= 5) break;
         if (fifo_full) seen_full = 1'b1;
         step();
      end
      check("all_fifo_full_seen", int'(seen_full), 1);
      check("all_delivered_n", delivered.size(), 5);
      for (int k = 0; k < 5; k++)
         check("all_order", (k < delivered.size()) ? delivered[k] : -1, k + 1);
      check("all_req_dropped", int'(co_req), 0);
      check("all_count_sat", int'(box_count), 3);

      // Single request from line 2.
      reset = 1'b1; step(); reset = 1'b0;
      check("single_count0", int'(box_count), 0);
      co_req = 5'b00100;
      run_pack(100, 0, took);
      check("single_latency", took, 14);
      check("single_code", int'(box_code), 3);
      step();
      check("single_count", int'(box_count), 1);
      check("single_valid_drop", int'(box_valid), 0);

      // Held box under backpressure.
      box_ready = 1'b0; co_req = 5'b00001;
      run_pack(100, 0, took);
      check("bp_latency", took, 14);
      for (int i = 0; i < 20; i++) step();
      check("bp_valid_held", int'(box_valid), 1);
      check("bp_code_held", int'(box_code), 1);
      check("bp_count_held", int'(box_count), 1);
      box_ready = 1'b1; step();
      check("bp_count_after", int'(box_count), 2);

      // stop for 5 cycles while packing.
      co_req = 5'b00010;
      run_pack(4, 5, took);
      check("stop_latency", took, 19);
      check("stop_code", int'(box_code), 2);
      step();
      check("stop_count", int'(box_count), 3);

      // Reset in the middle of a pack with two more requests queued.
      reset = 1'b1; step(); reset = 1'b0;
      co_req = 5'b00001;
      for (int i = 0; i < 3; i++) step();
      co_req = co_req | 5'b00110;
      for (int i = 0; i < 5; i++) step();
      check("mid_busy_before", int'(pack_busy), 1);
      reset = 1'b1; step(); reset = 1'b0; co_req = '0;
      check("mid_fifo_full", int'(fifo_full), 0);
      check("mid_busy_after", int'(pack_busy), 0);
      check("mid_count", int'(box_count), 0);
      highs = 0;
      for (int i = 0; i < 30; i++) begin
         if (box_valid || pack_busy) highs++;
         step();
      end
      check("mid_no_activity", highs, 0);

      // Five sequential boxes with a 2-bit counter.
      for (int b = 0; b < 5; b++) begin
         co_req = 5'(1 << (b % 5));
         run_pack(100, 0, took);
         check("sat_latency", took, 14);
         check("sat_code", int'(box_code), b + 1);
         step();
         check("sat_count", int'(box_count), (b + 1 < 3) ? b + 1 : 3);
      end

      step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
